axis_conv_window: RTL and testbench

- Downstream consumer of the 784-pixel AXI-stream image buffer.
- Takes one row-major IMGW x IMGH frame and produces every valid KxK convolution window (stride 1, no padding) as one flattened word per beat, for the conv MAC array.
- Uses K-1 line buffers plus a KxK shift-register window.
- Uses the same ex_start/ex_startAck arming handshake as the upstream buffer.

---
 rtl/axis_conv_window.sv | 153 +++++++++++++++
 tb/tb_axis_conv_window.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_conv_window.sv
// axis_conv_window: streams a row-major IMGW x IMGH frame and emits every valid
// KxK window (stride 1, no padding) as one flattened word per output beat.
// Optional build macro: AXIS_CONV_WINDOW_LASTCHK_EN adds a sticky err_last flag
// for an early or missing s_last. The frame is always delimited by pixel count.
module axis_conv_window #(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned IMGW      = 28,
  parameter int unsigned IMGH      = 28,
  parameter int unsigned K         = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ex_start,
  output logic                         ex_startAck,
  input  logic [DATAWIDTH-1:0]         s_data,
  input  logic                         s_valid,
  input  logic                         s_last,
  output logic                         s_ready,
  output logic [K*K*DATAWIDTH-1:0]     m_win,
  output logic                         m_valid,
  output logic                         m_last,
  input  logic                         m_ready
`ifdef AXIS_CONV_WINDOW_LASTCHK_EN
  ,
  output logic                         err_last
`endif
);

  localparam int unsigned COL_W = $clog2(IMGW);
  localparam int unsigned ROW_W = $clog2(IMGH);
  // Newest pixel plus K-1 full lines plus K-1 pixels of the oldest window row.
  localparam int unsigned TAPS  = (K - 1) * IMGW + K;
  localparam int unsigned WIN_W = K * K * DATAWIDTH;

  typedef enum logic [1:0] {IDLE, START, RUN, DRAIN} state_t;

  state_t             state;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic               accept;
  logic               at_last_pix;
  logic               win_pos;
  logic [WIN_W-1:0]   win_c;

  // Line buffers and window share one tap chain; taps[n] is the pixel accepted n beats ago.
  logic [DATAWIDTH-1:0] taps [1:TAPS-1];

`ifndef AXIS_CONV_WINDOW_LASTCHK_EN
  logic unused_s_last;
  assign unused_s_last = s_last;
`endif

  // Input handshake and position decode of the pixel being offered.
  assign s_ready     = (state == RUN) && (!m_valid || m_ready);
  assign accept      = s_valid && s_ready;
  assign at_last_pix = (row == ROW_W'(IMGH - 1)) && (col == COL_W'(IMGW - 1));
  assign win_pos     = (row >= ROW_W'(K - 1)) && (col >= COL_W'(K - 1));

  // Shift accepted pixels through the line-buffer chain (contents need no reset).
  always_ff @(posedge clk) begin
    if (accept) begin
      taps[1] <= s_data;
      for (int k = 2; k < TAPS; k++) begin
        taps[k] <= taps[k-1];
      end
    end
  end

  // Assemble the window that includes the pixel currently being accepted.
  always_comb begin
    win_c = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        if ((i == K - 1) && (j == K - 1)) begin
          win_c[DATAWIDTH*(i*K+j) +: DATAWIDTH] = s_data;
        end else begin
          win_c[DATAWIDTH*(i*K+j) +: DATAWIDTH] = taps[(K-1-i)*IMGW + (K-1-j)];
        end
      end
    end
  end

  // Control FSM, position counters and the output window register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      col         <= '0;
      row         <= '0;
      ex_startAck <= 1'b0;
      m_win       <= '0;
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
`ifdef AXIS_CONV_WINDOW_LASTCHK_EN
      err_last    <= 1'b0;
`endif
    end else begin
      if (accept && win_pos) begin
        m_win   <= win_c;
        m_valid <= 1'b1;
        m_last  <= at_last_pix;
      end else if (m_ready) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end

      case (state)
        IDLE: begin
          col <= '0;
          row <= '0;
          if (ex_start) begin
            state       <= START;
            ex_startAck <= 1'b1;
`ifdef AXIS_CONV_WINDOW_LASTCHK_EN
            err_last    <= 1'b0;
`endif
          end
        end
        START: begin
          if (!ex_start) begin
            state       <= RUN;
            ex_startAck <= 1'b0;
          end
        end
        RUN: begin
          if (accept) begin
            if (at_last_pix) begin
              col   <= '0;
              row   <= '0;
              state <= DRAIN;
            end else if (col == COL_W'(IMGW - 1)) begin
              col <= '0;
              row <= row + ROW_W'(1);
            end else begin
              col <= col + COL_W'(1);
            end
`ifdef AXIS_CONV_WINDOW_LASTCHK_EN
            if (s_last != at_last_pix) begin
              err_last <= 1'b1;
            end
`endif
          end
        end
        DRAIN: begin
          if (m_valid && m_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_conv_window.sv
// Directed testbench for axis_conv_window with a formula-based window model.
module tb_axis_conv_window;

  localparam int unsigned DW   = 32;
  localparam int unsigned IMGW = 28;
  localparam int unsigned IMGH = 28;
  localparam int unsigned K    = 3;
  localparam int unsigned WW   = K * K * DW;
  localparam int          NPIX = IMGW * IMGH;
  localparam int          OW   = IMGW - K + 1;
  localparam int          NWIN = (IMGH - K + 1) * OW;
  localparam int          BR0  = (K - 1) * IMGW + K - 1;
  localparam int          MAXC = 20000;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b1;
  logic          ex_start = 1'b0;
  logic          ex_startAck;
  logic [DW-1:0] s_data   = '0;
  logic          s_valid  = 1'b0;
  logic          s_last   = 1'b0;
  logic          s_ready;
  logic [WW-1:0] m_win;
  logic          m_valid;
  logic          m_last;
  logic          m_ready  = 1'b0;
`ifdef AXIS_CONV_WINDOW_LASTCHK_EN
  logic          err_last;
`endif

  int errors = 0;
  int checks = 0;

  axis_conv_window #(.DATAWIDTH(DW), .IMGW(IMGW), .IMGH(IMGH), .K(K)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ex_start    (ex_start),
    .ex_startAck (ex_startAck),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .m_win       (m_win),
    .m_valid     (m_valid),
    .m_last      (m_last),
    .m_ready     (m_ready)
`ifdef AXIS_CONV_WINDOW_LASTCHK_EN
    ,
    .err_last    (err_last)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Window w (raster order of top-left corner) of a frame whose pixel n carries base+n.
  function automatic logic [WW-1:0] exp_win(input int base, input int w);
    logic [WW-1:0] v;
    int r0;
    int c0;
    v  = '0;
    r0 = w / OW;
    c0 = w % OW;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        v[DW*(i*K+j) +: DW] = DW'(base + (r0 + i) * IMGW + c0 + j);
      end
    end
    return v;
  endfunction

  function automatic logic [WW-1:0] pack9(input int a0, input int a1, input int a2,
                                          input int a3, input int a4, input int a5,
                                          input int a6, input int a7, input int a8);
    logic [WW-1:0] v;
    v = {DW'(a8), DW'(a7), DW'(a6), DW'(a5), DW'(a4), DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"},    ex_startAck, 0);
    check({tag, "_sready"}, s_ready,     0);
    check({tag, "_mvalid"}, m_valid,     0);
    check({tag, "_mlast"},  m_last,      0);
    check({tag, "_mwin"},   m_win,       0);
  endtask

  // Hold ex_start for n cycles, then release; ends in the first RUN cycle.
  task automatic arm(input int n);
    @(negedge clk);
    s_valid  = 1'b0;
    ex_start = 1'b1;
    #1;
    check("ack_pre", ex_startAck, 0);
    repeat (n) begin
      @(negedge clk);
      #1;
      check("ack_start", ex_startAck, 1);
      check("sready_start", s_ready, 0);
    end
    ex_start = 1'b0;
    @(negedge clk);
    #1;
    check("ack_run", ex_startAck, 0);
    check("sready_run", s_ready, 1);
`ifdef AXIS_CONV_WINDOW_LASTCHK_EN
    check("err_last_arm", err_last, 0);
`endif
  endtask

  // mode 0: full rate; 1: 10-cycle m_ready stall; 2: random s_valid/m_ready/ex_start.
  task automatic run_frame(input int base, input int mode, input int abort_at, input int last_at);
    int idx, nwin, cyc, acc_br, first_v;
    bit prev_hold, done, err_exp;
    logic [WW-1:0] prev_win;
    idx = 0; nwin = 0; cyc = 0; acc_br = -1; first_v = -1;
    prev_hold = 1'b0; done = 1'b0; err_exp = 1'b0; prev_win = '0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      case (mode)
        1:       m_ready = !(cyc >= 400 && cyc < 410);
        2:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b1;
      endcase
      s_valid  = (idx < NPIX) && (mode != 2 || $urandom_range(0, 1) == 1);
      ex_start = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      s_data   = DW'(base + idx);
      s_last   = (idx == last_at);
      #1;
`ifdef AXIS_CONV_WINDOW_LASTCHK_EN
      check("err_last", err_last, err_exp);
`endif
      if (prev_hold) begin
        check("hold_valid", m_valid, 1);
        check("hold_win", m_win, prev_win);
      end
      if (m_valid && !m_ready) check("bp_sready", s_ready, 0);
      if (m_valid && first_v < 0) first_v = cyc;
      if (m_valid && m_ready) begin
        check("win", m_win, exp_win(base, nwin));
        check("win_last", m_last, (nwin == NWIN - 1));
        if (base == 0 && nwin == 0)  check("win_first_hand", m_win, pack9(0, 1, 2, 28, 29, 30, 56, 57, 58));
        if (base == 0 && nwin == 26) check("win_26_hand", m_win, pack9(28, 29, 30, 56, 57, 58, 84, 85, 86));
        if (base == 0 && nwin == NWIN - 1)
          check("win_final_hand", m_win, pack9(725, 726, 727, 753, 754, 755, 781, 782, 783));
        nwin++;
      end
      if (s_valid && s_ready) begin
        if (idx == BR0) acc_br = cyc;
        if (s_last != (idx == NPIX - 1)) err_exp = 1'b1;
        idx++;
      end
      prev_hold = m_valid && !m_ready;
      prev_win  = m_win;
      if (nwin == NWIN || (abort_at > 0 && idx == abort_at)) begin
        done = 1'b1;
      end else if (cyc >= MAXC) begin
        check("timeout_windows", nwin, NWIN);
        done = 1'b1;
      end
    end
    ex_start = 1'b0;
    if (abort_at > 0) begin
      @(posedge clk);
      #1;
      s_valid = 1'b0;
    end else begin
      s_valid = 1'b0;
      check("pix_count", idx, NPIX);
      if (mode == 0) check("latency", first_v, acc_br + 1);
      @(negedge clk);
      #1;
      check("post_mvalid", m_valid, 0);
      check("post_sready", s_ready, 0);
      check("post_ack", ex_startAck, 0);
`ifdef AXIS_CONV_WINDOW_LASTCHK_EN
      check("err_last_end", err_last, err_exp);
`endif
    end
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    arm(3);
    run_frame(0, 0, 0, NPIX - 1);
    arm(1);
    run_frame(100000, 1, 0, NPIX - 1);
    arm(2);
    run_frame(200000, 2, 0, NPIX - 1);

    arm(1);
    run_frame(300000, 0, 301, NPIX - 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    arm(1);
    run_frame(400000, 0, 0, NPIX - 1);

`ifdef AXIS_CONV_WINDOW_LASTCHK_EN
    arm(1);
    run_frame(500000, 0, 0, 500);
    arm(1);
    run_frame(600000, 0, 0, NPIX - 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
